// File: rtl/ir_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ir_tx_pkg: shared types and default timing for the IR transmitter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ir_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SELECT = 3'd2,
    DATA   = 3'd3,
    GAP    = 3'd4
  } ir_state_t;

  // Half-period minus one at 100 MHz gives a carrier close to 36 kHz.
  localparam int c_def_clk_div_half   = 1388;
  localparam int c_def_start_burst    = 192;
  localparam int c_def_select_burst   = 24;
  localparam int c_def_gap_len        = 24;
  localparam int c_def_assert_burst   = 48;
  localparam int c_def_deassert_burst = 24;
  localparam int c_def_num_cmd        = 4;
  localparam int c_def_cnt_w          = 8;

endpackage
`default_nettype wire

// File: rtl/ir_carrier_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ir_carrier_gen: square-wave carrier with one-cycle tick per period   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ir_carrier_gen
  import ir_tx_pkg::*;
#(
  parameter int CLK_DIV_HALF = c_def_clk_div_half
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  input  logic RESTART,
  output logic CARRIER,
  output logic TICK
);

  localparam int c_div_w = (CLK_DIV_HALF > 0) ? $clog2(CLK_DIV_HALF + 1) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV_HALF);

  logic [c_div_w-1:0] div_cnt_q;
  logic               carrier_q;
  logic               carrier_dly_q;

  // RESTART clears the delayed copy as well, so no falling edge is seen on restart.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE || RESTART) begin
      div_cnt_q     <= '0;
      carrier_q     <= 1'b0;
      carrier_dly_q <= 1'b0;
    end else begin
      carrier_dly_q <= carrier_q;
      if (div_cnt_q == c_div_last) begin
        div_cnt_q <= '0;
        carrier_q <= ~carrier_q;
      end else begin
        div_cnt_q <= div_cnt_q + c_div_w'(1);
      end
    end
  end

  assign CARRIER = carrier_q;
  assign TICK    = carrier_dly_q & ~carrier_q;

endmodule
`default_nettype wire

// File: rtl/ir_packet_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ir_packet_tx: serialises start/select/command bursts onto the IR LED |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ir_packet_tx
  import ir_tx_pkg::*;
#(
  parameter int CLK_DIV_HALF   = c_def_clk_div_half,
  parameter int START_BURST    = c_def_start_burst,
  parameter int SELECT_BURST   = c_def_select_burst,
  parameter int GAP_LEN        = c_def_gap_len,
  parameter int ASSERT_BURST   = c_def_assert_burst,
  parameter int DEASSERT_BURST = c_def_deassert_burst,
  parameter int NUM_CMD        = c_def_num_cmd,
  parameter int CNT_W          = c_def_cnt_w
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [NUM_CMD-1:0] COMMAND,
  input  logic               SEND_PACKET,
  output logic               BUSY,
  output logic               DONE,
  output logic               IR_LED
);

  localparam int c_idx_w = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CMD - 1);

  ir_state_t          state_q;
  ir_state_t          after_gap_q;
  logic [NUM_CMD-1:0] cmd_q;
  logic [c_idx_w-1:0] idx_q;
  logic [CNT_W-1:0]   burst_cnt_q;
  logic               led_en_q;
  logic               busy_q;
  logic               done_q;

  logic               w_carrier;
  logic               w_tick;
  logic               w_accept;
  logic               w_seg_end;
  logic [CNT_W-1:0]   w_seg_len;

  assign w_accept = (state_q == IDLE) && SEND_PACKET;

  ir_carrier_gen #(
    .CLK_DIV_HALF(CLK_DIV_HALF)
  ) u_carrier (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .RESTART (w_accept),
    .CARRIER (w_carrier),
    .TICK    (w_tick)
  );

  always_comb begin
    w_seg_len = '0;
    case (state_q)
      START:   w_seg_len = CNT_W'(START_BURST);
      SELECT:  w_seg_len = CNT_W'(SELECT_BURST);
      GAP:     w_seg_len = CNT_W'(GAP_LEN);
      DATA:    w_seg_len = cmd_q[idx_q] ? CNT_W'(ASSERT_BURST) : CNT_W'(DEASSERT_BURST);
      default: w_seg_len = '0;
    endcase
  end

  assign w_seg_end = (burst_cnt_q == w_seg_len);

  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      state_q     <= IDLE;
      after_gap_q <= IDLE;
      cmd_q       <= '0;
      idx_q       <= '0;
      burst_cnt_q <= '0;
      led_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SEND_PACKET) begin
            state_q     <= START;
            cmd_q       <= COMMAND;
            idx_q       <= '0;
            burst_cnt_q <= '0;
            led_en_q    <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          if (w_seg_end) begin
            burst_cnt_q <= '0;
            if (state_q == GAP) begin
              state_q  <= after_gap_q;
              led_en_q <= (after_gap_q != IDLE);
              busy_q   <= (after_gap_q != IDLE);
              done_q   <= (after_gap_q == IDLE);
            end else begin
              state_q  <= GAP;
              led_en_q <= 1'b0;
              // Every burst is followed by a gap; remember where to resume.
              case (state_q)
                START:   after_gap_q <= SELECT;
                SELECT:  after_gap_q <= DATA;
                default: begin
                  idx_q       <= idx_q + c_idx_w'(1);
                  after_gap_q <= (idx_q == c_last_idx) ? IDLE : DATA;
                end
              endcase
            end
          end else if (w_tick) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign IR_LED = w_carrier & led_en_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_packet_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ir_packet_tx: directed bench with a timeline model of the packet  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ir_packet_tx;

  localparam int CDH  = 3;
  localparam int SB   = 4;
  localparam int SLB  = 2;
  localparam int GL   = 2;
  localparam int AB   = 3;
  localparam int DB   = 1;
  localparam int NC   = 4;
  localparam int CW   = 8;
  localparam int HALF = CDH + 1;
  localparam int TP   = 2 * HALF;
  localparam int NSEG = 4 + 2 * NC;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ENABLE = 1'b1;
  logic          SEND_PACKET = 1'b0;
  logic [NC-1:0] COMMAND = '0;
  logic          BUSY;
  logic          DONE;
  logic          IR_LED;

  always #5 CLK = ~CLK;

  ir_packet_tx #(
    .CLK_DIV_HALF(CDH), .START_BURST(SB), .SELECT_BURST(SLB), .GAP_LEN(GL),
    .ASSERT_BURST(AB), .DEASSERT_BURST(DB), .NUM_CMD(NC), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .COMMAND(COMMAND),
    .SEND_PACKET(SEND_PACKET), .BUSY(BUSY), .DONE(DONE), .IR_LED(IR_LED)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a packet is a list of segments measured in carrier periods.
  // Ticks fall at cycles TP*m after acceptance; a segment ending on tick M
  // hands over to the next one at cycle TP*M+2.
  int seg_end[NSEG];
  bit seg_on[NSEG];
  int m_k    = -1;
  int m_ph   = 0;
  int m_done = 0;

  function automatic void build_packet(input logic [NC-1:0] c);
    int acc = 0;
    acc += SB;  seg_end[0] = acc; seg_on[0] = 1'b1;
    acc += GL;  seg_end[1] = acc; seg_on[1] = 1'b0;
    acc += SLB; seg_end[2] = acc; seg_on[2] = 1'b1;
    acc += GL;  seg_end[3] = acc; seg_on[3] = 1'b0;
    for (int b = 0; b < NC; b++) begin
      acc += c[b] ? AB : DB; seg_end[4+2*b] = acc; seg_on[4+2*b] = 1'b1;
      acc += GL;             seg_end[5+2*b] = acc; seg_on[5+2*b] = 1'b0;
    end
    m_done = TP * acc + 2;
  endfunction

  function automatic bit in_burst(input int k);
    int lo;
    for (int j = 0; j < NSEG; j++) begin
      lo = 0;
      if (j > 0) lo = TP * seg_end[j-1] + 2;
      if (k >= lo && k <= TP * seg_end[j] + 1) return seg_on[j];
    end
    return 1'b0;
  endfunction

  initial forever begin
    @(posedge CLK);
    if (RESET || !ENABLE) begin
      m_k  = -1;
      m_ph = 0;
    end else if ((m_k < 0 || m_k >= m_done) && SEND_PACKET) begin
      build_packet(COMMAND);
      m_k  = 0;
      m_ph = 0;
    end else begin
      m_ph++;
      if (m_k >= 0) m_k++;
    end
  end

  // Monitor state for the literal checks.
  int done_cnt = 0;
  int cur      = 0;
  int dark     = 100;
  int hi_run   = 0;
  int lo_run   = 0;
  bit led_prev = 1'b0;
  bit busy_prev = 1'b0;
  int bursts[$];
  int busy_runs[$];
  int low_runs[$];

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      bit eb;
      eb = (m_k >= 0) && (m_k < m_done);
      check("busy", int'(BUSY), int'(eb));
      check("done", int'(DONE), int'((m_k >= 0) && (m_k == m_done)));
      check("ir_led", int'(IR_LED), int'(eb && in_burst(m_k) && ((m_ph / HALF) % 2 == 1)));
    end
    if (DONE) done_cnt++;
    if (IR_LED && !led_prev) begin
      if (dark > TP && cur > 0) begin
        bursts.push_back(cur);
        cur = 1;
      end else begin
        cur++;
      end
    end
    dark = IR_LED ? 0 : dark + 1;
    led_prev = IR_LED;
    if (BUSY && !busy_prev) begin low_runs.push_back(lo_run); lo_run = 0; end
    if (!BUSY && busy_prev) begin busy_runs.push_back(hi_run); hi_run = 0; end
    if (BUSY) hi_run++; else lo_run++;
    busy_prev = BUSY;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    bursts.delete();
    busy_runs.delete();
    low_runs.delete();
    cur  = 0;
    dark = 100;
  endtask

  task automatic flush_bursts();
    if (cur > 0) bursts.push_back(cur);
    cur = 0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic check_bursts(input string name, input int e0, input int e1,
                              input int e2, input int e3, input int e4, input int e5);
    int e[6];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4; e[5] = e5;
    check({name, "_nbursts"}, bursts.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_burst%0d", name, i), (i < bursts.size()) ? bursts[i] : -1, e[i]);
  endtask

  task automatic send_pulse(input logic [NC-1:0] cmd);
    COMMAND = cmd;
    SEND_PACKET = 1'b1;
    step();
    SEND_PACKET = 1'b0;
  endtask

  initial begin
    int d0;
    @(posedge CLK);
    #1 chk_en = 1'b1;
    repeat (2) step();
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_led", int'(IR_LED), 0);
    repeat (50) step();
    check("idle_no_done", done_cnt, 0);

    // Packet A: latched command, late COMMAND change, ignored mid-packet request.
    clear_mon();
    d0 = done_cnt;
    send_pulse(4'b0101);
    COMMAND = 4'b1111;
    @(negedge CLK);
    check("a_busy_next", int'(BUSY), 1);
    repeat (60) step();
    SEND_PACKET = 1'b1;
    step();
    SEND_PACKET = 1'b0;
    wait_done("a", 400);
    repeat (3) step();
    flush_bursts();
    check("a_done_count", done_cnt - d0, 1);
    check("a_nbusy", busy_runs.size(), 1);
    check("a_busy_len", (busy_runs.size() > 0) ? busy_runs[0] : -1, 210);
    check_bursts("a", 4, 2, 3, 1, 3, 1);

    // Packet B: reset while DATA(1) is lighting the LED.
    d0 = done_cnt;
    send_pulse(4'b0101);
    repeat (124) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    @(negedge CLK);
    check("b_rst_busy", int'(BUSY), 0);
    check("b_rst_led", int'(IR_LED), 0);
    repeat (40) step();
    check("b_no_done", done_cnt - d0, 0);

    // Packet C: full packet after the abort.
    clear_mon();
    d0 = done_cnt;
    send_pulse(4'b1000);
    wait_done("c", 400);
    repeat (3) step();
    flush_bursts();
    check("c_done_count", done_cnt - d0, 1);
    check("c_busy_len", (busy_runs.size() > 0) ? busy_runs[0] : -1, 194);
    check_bursts("c", 4, 2, 1, 1, 1, 3);

    // Packet D: request held high gives back-to-back packets.
    clear_mon();
    d0 = done_cnt;
    COMMAND = '0;
    SEND_PACKET = 1'b1;
    wait_done("d1", 400);
    wait_done("d2", 400);
    step();
    SEND_PACKET = 1'b0;
    wait_done("d3", 400);
    repeat (5) step();
    check("d_done_count", done_cnt - d0, 3);
    check("d_nbusy", busy_runs.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("d_busy_len%0d", i), (i < busy_runs.size()) ? busy_runs[i] : -1, 178);
    check("d_nlow", low_runs.size(), 3);
    check("d_low1", (low_runs.size() > 1) ? low_runs[1] : -1, 1);
    check("d_low2", (low_runs.size() > 2) ? low_runs[2] : -1, 1);

    // Packet E: ENABLE low acts as reset.
    d0 = done_cnt;
    send_pulse(4'b0011);
    repeat (40) step();
    ENABLE = 1'b0;
    step();
    ENABLE = 1'b1;
    @(negedge CLK);
    check("e_dis_busy", int'(BUSY), 0);
    repeat (20) step();
    check("e_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
